// File: rtl/mysystem_nios2_mul_seq.sv
// Two-pass 32x32 (low word) multiply sequencer wrapped around a 32x16 multiply cell.
// Low half of src2 goes through the cell first, then the high half; partials are merged as lo + (hi << 16).
module mysystem_nios2_mul_seq #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] mul_src1,
  input  logic [31:0] mul_src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] mul_result,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_HI,
    WAIT,
    CAP_LO,
    CAP_HI
  } state_e;

  localparam logic [1:0] LAT_M1 = 2'(CELL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [31:0] a_src1_q, a_src1_d;
  logic [31:0] a_src2_q, a_src2_d;
  logic [15:0] b_hi_q, b_hi_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] lo_acc_q, lo_acc_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // NOTE: every register here is a small flop with a defined reset value; none of this
  // state is a memory array, so resetting all of it costs nothing and keeps aborts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_src1_q  <= '0;
      a_src2_q  <= '0;
      b_hi_q    <= '0;
      lat_cnt_q <= '0;
      lo_acc_q  <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_src1_q  <= a_src1_d;
      a_src2_q  <= a_src2_d;
      b_hi_q    <= b_hi_d;
      lat_cnt_q <= lat_cnt_d;
      lo_acc_q  <= lo_acc_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every _d gets its hold value before the case statement, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    a_src1_d  = a_src1_q;
    a_src2_d  = a_src2_q;
    b_hi_d    = b_hi_q;
    lat_cnt_d = lat_cnt_q;
    lo_acc_d  = lo_acc_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_src1_d = mul_src1;
          a_src2_d = {16'h0, mul_src2[15:0]};
          b_hi_d   = mul_src2[31:16];
          busy_d   = 1'b1;
          state_d  = ISSUE_HI;
        end
      end
      ISSUE_HI: begin
        a_src2_d  = {16'h0, b_hi_q};
        lat_cnt_d = LAT_M1;
        state_d   = (CELL_LATENCY > 1) ? WAIT : CAP_LO;
      end
      WAIT: begin
        // Stays here CELL_LATENCY-1 cycles so CAP_LO lines up with the low partial.
        lat_cnt_d = lat_cnt_q - 2'd1;
        if (lat_cnt_q == 2'd1) begin
          state_d = CAP_LO;
        end
      end
      CAP_LO: begin
        lo_acc_d = A_mul_cell_result;
        state_d  = CAP_HI;
      end
      CAP_HI: begin
        // Only bits [15:0] of the high partial survive the shift into a 32-bit result.
        result_d = lo_acc_q + {A_mul_cell_result[15:0], 16'h0};
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mul_result = result_q;
  assign A_mul_src1 = a_src1_q;
  assign A_mul_src2 = a_src2_q;

endmodule

// File: tb/tb_mysystem_nios2_mul_seq.sv
// Bench for the two-pass multiply sequencer: one instance at cell latency 1, one at 3,
// each with its own multiply-cell model, expected-result queue and done monitor.
module tb_mysystem_nios2_mul_seq;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Latency-1 instance
  logic        rst1_n, start1, busy1, done1;
  logic [31:0] src1_1, src2_1, res1, a1_src1, a1_src2, cell1;
  // Latency-3 instance
  logic        rst3_n, start3, busy3, done3;
  logic [31:0] src1_3, src2_3, res3, a3_src1, a3_src2, cell3;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  mysystem_nios2_mul_seq #(.CELL_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .start(start1), .mul_src1(src1_1), .mul_src2(src2_1),
    .busy(busy1), .done(done1), .mul_result(res1),
    .A_mul_src1(a1_src1), .A_mul_src2(a1_src2), .A_mul_cell_result(cell1)
  );

  mysystem_nios2_mul_seq #(.CELL_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .start(start3), .mul_src1(src1_3), .mul_src2(src2_3),
    .busy(busy3), .done(done3), .mul_result(res3),
    .A_mul_src1(a3_src1), .A_mul_src2(a3_src2), .A_mul_cell_result(cell3)
  );

  // Multiply cell models: low 32 bits of the operand product, delayed by the cell latency.
  logic [31:0] c1_p0;
  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) c1_p0 <= '0;
    else         c1_p0 <= a1_src1 * a1_src2;
  end
  assign cell1 = c1_p0;

  logic [31:0] c3_p0, c3_p1, c3_p2;
  always @(posedge clk or negedge rst3_n) begin
    if (!rst3_n) begin
      c3_p0 <= '0;
      c3_p1 <= '0;
      c3_p2 <= '0;
    end else begin
      c3_p0 <= a3_src1 * a3_src2;
      c3_p1 <= c3_p0;
      c3_p2 <= c3_p1;
    end
  end
  assign cell3 = c3_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation, in value and cycle.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check("done1_spurious", {31'b0, done1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("result1", res1, e1.res);
        check("done1_cycle", cyc, e1.cyc);
      end
    end
    if (done3) begin
      if (q3.size() == 0) begin
        check("done3_spurious", {31'b0, done3}, 32'd0);
      end else begin
        e3 = q3.pop_front();
        check("result3", res3, e3.res);
        check("done3_cycle", cyc, e3.cyc);
      end
    end
  end

  // Called at posedge+1 of cycle 0; returns at posedge+1 of the done cycle.
  // While busy, start is randomly pulsed with junk operands that must be ignored.
  task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int lat;
    exp_t e;
    lat   = (which == 3) ? 3 : 1;
    e.res = exp;
    e.cyc = cyc + lat + 3;
    if (which == 3) begin
      q3.push_back(e);
      start3 = 1'b1; src1_3 = a; src2_3 = b;
    end else begin
      q1.push_back(e);
      start1 = 1'b1; src1_1 = a; src2_1 = b;
    end
    for (int i = 0; i < lat + 3; i++) begin
      @(posedge clk);
      #1;
      if (which == 3) begin
        start3 = (i < lat + 2) && ($urandom_range(0, 3) == 0);
        src1_3 = $urandom; src2_3 = $urandom;
      end else begin
        start1 = (i < lat + 2) && ($urandom_range(0, 3) == 0);
        src1_1 = $urandom; src2_1 = $urandom;
      end
    end
  endtask

  // Latency-1 operation with per-cycle visibility of cell operands, partials and busy.
  task automatic traced_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    exp_t e;
    e.res = exp;
    e.cyc = cyc + 4;
    q1.push_back(e);
    start1 = 1'b1; src1_1 = a; src2_1 = b;
    @(negedge clk);
    check("c0_busy", {31'b0, busy1}, 32'd0);
    @(posedge clk); #1;
    start1 = 1'b0; src1_1 = $urandom; src2_1 = $urandom;
    @(negedge clk);
    check("c1_src1", a1_src1, a);
    check("c1_src2_lo", a1_src2, {16'h0, b[15:0]});
    check("c1_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    check("c2_src2_hi", a1_src2, {16'h0, b[31:16]});
    check("c2_lo_partial", cell1, exp_lo);
    check("c2_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    check("c3_hi_partial", cell1, exp_hi);
    check("c3_busy", {31'b0, busy1}, 32'd1);
    check("c3_done", {31'b0, done1}, 32'd0);
    @(negedge clk);
    check("c4_busy", {31'b0, busy1}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst1_n = 1'b0; rst3_n = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    src1_1 = '0; src2_1 = '0; src1_3 = '0; src2_3 = '0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy1}, 32'd0);
    check("rst_done", {31'b0, done1}, 32'd0);
    check("rst_result", res1, 32'd0);
    check("rst_a_src1", a1_src1, 32'd0);
    check("rst_a_src2", a1_src2, 32'd0);
    idle(2);
    rst1_n = 1'b1; rst3_n = 1'b1;
    idle(2);

    traced_op(32'd7, 32'd6, 32'h0000_002A, 32'd42, 32'd0);
    traced_op(32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32'h0001_0001, 32'h0001_0001);
    traced_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_0001, 32'hFFFF_0001);
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080);
    idle(1);

    // Abort mid-operation: outputs clear at once and the aborted op never completes.
    start1 = 1'b1; src1_1 = 32'h0000_1111; src2_1 = 32'h0000_0003;
    idle(1);
    start1 = 1'b0;
    idle(1);
    rst1_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy1}, 32'd0);
    check("abort_done", {31'b0, done1}, 32'd0);
    check("abort_result", res1, 32'd0);
    idle(1);
    rst1_n = 1'b1;
    idle(8);
    issue(1, 32'd2, 32'd3, 32'd6);
    idle(3);
    check("result_hold", res1, 32'd6);

    // Back-to-back: a start in cycle 2 is ignored, the next start lands in the done cycle.
    begin
      exp_t e;
      e.res = 32'h0000_000F;
      e.cyc = cyc + 4;
      q1.push_back(e);
      start1 = 1'b1; src1_1 = 32'd3; src2_1 = 32'd5;
      idle(1);
      start1 = 1'b0;
      idle(1);
      start1 = 1'b1; src1_1 = 32'd9; src2_1 = 32'd9;
      idle(1);
      start1 = 1'b0;
      idle(1);
      issue(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    end
    idle(2);

    issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    idle(1);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom;
      issue(1, ra, rb, ra * rb);
      idle($urandom_range(0, 2));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 8 == 0) rb[31:16] = 16'hFFFF;
      issue(3, ra, rb, ra * rb);
      idle($urandom_range(0, 1));
    end

    idle(4);
    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
